// File: rtl/bin_reader_pkg.sv
// Shared definitions for the PMT bin count reader.
//   state_t     : frame FSM state (IDLE, HDR, MSB, LSB)
//   FRAME_BYTES : bytes per host frame (index, count MSB, count LSB)
//   COUNT_W     : width of a bin photon count
package bin_reader_pkg;

  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned FRAME_BYTES = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    MSB  = 2'd2,
    LSB  = 2'd3
  } state_t;

endpackage

// File: rtl/bin_fifo.sv
// Synchronous FIFO holding tagged bin entries.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en, din   : push din (ignored when full unless popping the same cycle)
//   rd_en, dout  : pop head into the dout register (ignored when empty)
//   full, empty  : occupancy flags
//   level        : number of stored entries (0..DEPTH)
module bin_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned W     = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [W-1:0]  din,
  input  logic          rd_en,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // A push into a full FIFO is legal when the head leaves on the same edge;
  // the read below samples the old slot contents before the write lands.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      dout  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/bin_count_reader.sv
// Reader side of the per-time-bin PMT photon counter.
// Captures {bin_idx, count_in} on each bin_end strobe into a FIFO and streams
// each entry to the host as a 3-byte frame: bin_idx, count[15:8], count[7:0].
//   clk, reset_n : clock, asynchronous active-low reset
//   bin_end      : 1-cycle strobe, count_in valid this cycle
//   count_in     : photon count of the closing bin
//   tx_data      : frame byte, tx_valid : byte valid, tx_ready : sink accepts
//   overflow     : sticky, a bin was dropped on a full FIFO
//   fifo_level   : entries stored in the FIFO (excludes the frame in flight)
//   busy         : a frame is being transmitted
module bin_count_reader
  import bin_reader_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FIFO_AW    = 3,
  parameter int unsigned IDX_W      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               bin_end,
  input  logic [COUNT_W-1:0] count_in,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               busy
);

  localparam int unsigned FRAME_W = FRAME_BYTES * 8;

  state_t             state;
  logic               pend;
  logic [IDX_W-1:0]   bin_idx;
  logic               pop;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FRAME_W-1:0] frame;

  // The FIFO output register doubles as the frame register: it only changes
  // on a pop, and pops happen only between frames or on the LSB accept edge.
  // Taking the bytes straight from it is what allows back-to-back frames
  // without an idle cycle.
  bin_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW),
    .W     (FRAME_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (push),
    .din     ({bin_idx, count_in}),
    .rd_en   (pop),
    .dout    (frame),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // Pop from IDLE once (pend marks the cycle the popped entry settles into
  // the frame register), or chain directly on the LSB accept.
  assign pop = !fifo_empty &&
               ((state == IDLE && !pend) ||
                (state == LSB && tx_valid && tx_ready));

  assign push = bin_end && (!fifo_full || pop);
  assign busy = (state != IDLE);

  always_comb begin
    tx_data = '0;
    unique case (state)
      HDR:     tx_data = frame[FRAME_W-1 -: 8];
      MSB:     tx_data = frame[COUNT_W-1 -: 8];
      LSB:     tx_data = frame[7:0];
      default: tx_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_idx  <= '0;
      overflow <= 1'b0;
    end else if (bin_end) begin
      // Index advances on dropped bins too so the host sees the gap.
      bin_idx <= bin_idx + 1'b1;
      if (fifo_full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pend     <= 1'b0;
      tx_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pend) begin
            pend     <= 1'b0;
            state    <= HDR;
            tx_valid <= 1'b1;
          end else if (!fifo_empty) begin
            pend <= 1'b1;
          end
        end
        HDR: if (tx_valid && tx_ready) state <= MSB;
        MSB: if (tx_valid && tx_ready) state <= LSB;
        LSB: begin
          if (tx_valid && tx_ready) begin
            if (!fifo_empty) begin
              state <= HDR;
            end else begin
              state    <= IDLE;
              tx_valid <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_count_reader.sv
module tb_bin_count_reader;
  import bin_reader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bin_end = 1'b0;
  logic [15:0] count_in = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        overflow;
  logic [3:0]  fifo_level;
  logic        busy;

  int checks = 0;
  int failures = 0;

  bin_count_reader #(
    .FIFO_DEPTH (8),
    .FIFO_AW    (3),
    .IDX_W      (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bin_end    (bin_end),
    .count_in   (count_in),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: a bounded queue of stored entries, the frame
  // currently on the wire with its remaining byte count, and a one-cycle
  // load delay after a pop from idle.
  logic [23:0] mq[$];
  logic [23:0] cur;
  logic [23:0] pend_e;
  int          bleft;
  bit          loading;
  logic [7:0]  m_idx;
  bit          m_ovf;
  logic [7:0]  hdr_q[$];

  task automatic model_reset();
    mq.delete();
    cur = '0;
    pend_e = '0;
    bleft = 0;
    loading = 0;
    m_idx = '0;
    m_ovf = 0;
  endtask

  function automatic logic [7:0] exp_byte();
    logic [23:0] t;
    t = cur >> (8 * (bleft - 1));
    return t[7:0];
  endfunction

  task automatic model_step(input bit be, input logic [15:0] cnt, input bit rdy);
    if (bleft > 0) begin
      if (rdy) begin
        bleft--;
        if (bleft == 0 && mq.size() > 0) begin
          cur = mq.pop_front();
          bleft = 3;
        end
      end
    end else if (loading) begin
      loading = 0;
      cur = pend_e;
      bleft = 3;
    end else if (mq.size() > 0) begin
      pend_e = mq.pop_front();
      loading = 1;
    end
    if (be) begin
      if (mq.size() < 8) mq.push_back({m_idx, cnt});
      else m_ovf = 1;
      m_idx++;
    end
  endtask

  // One clock: drive inputs after a negedge, let the edge happen, advance the
  // model, and return at the next negedge where outputs are sampled.
  task automatic tick(input bit be, input logic [15:0] cnt, input bit rdy);
    bin_end = be;
    count_in = cnt;
    tx_ready = rdy;
    if (bleft == 3 && rdy) hdr_q.push_back(tx_data);
    @(posedge clk);
    model_step(be, cnt, rdy);
    @(negedge clk);
    bin_end = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bin_end = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    hdr_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks += 5;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid: got %0h expected 0", tx_valid); end
    if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %0h expected 0", overflow); end
    if (fifo_level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0h expected 0", busy); end
    reset_n = 1'b1;
    model_reset();
    hdr_q.delete();
  endtask

  task automatic test_single();
    logic [7:0] exp_seq[3];
    int nb;
    int busy_cnt;
    exp_seq[0] = 8'h00; exp_seq[1] = 8'h12; exp_seq[2] = 8'h34;
    do_reset();
    tick(1, 16'h1234, 1);
    tick(0, 16'h0000, 1);
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_latency_early: got %0h expected 0", tx_valid); end
    nb = 0;
    busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 16'h0000, 1);
      if (busy === 1'b1) busy_cnt++;
      if (i < 3) begin
        checks += 2;
        if (tx_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d]: got %0h expected 1", i, tx_valid); end
        if (tx_data !== exp_seq[i]) begin failures++; $display("FAIL single_byte[%0d]: got %0h expected %0h", i, tx_data, exp_seq[i]); end
        nb++;
      end else begin
        checks++;
        if (tx_valid !== 1'b0) begin failures++; $display("FAIL single_idle[%0d]: got %0h expected 0", i, tx_valid); end
      end
    end
    checks++;
    if (busy_cnt != 3) begin failures++; $display("FAIL single_busy_cycles: got %0d expected 3", busy_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    tick(1, 16'h12AB, 1);
    tick(0, 16'h0000, 1);
    tick(0, 16'h0000, 1);
    tick(0, 16'h0000, 1);
    for (int i = 0; i < 5; i++) begin
      tick(0, 16'h0000, 0);
      checks += 2;
      if (tx_valid !== 1'b1) begin failures++; $display("FAIL bp_valid[%0d]: got %0h expected 1", i, tx_valid); end
      if (tx_data !== 8'h12) begin failures++; $display("FAIL bp_hold[%0d]: got %0h expected 12", i, tx_data); end
    end
    tick(0, 16'h0000, 1);
    checks++;
    if (tx_data !== 8'hAB || tx_valid !== 1'b1) begin failures++; $display("FAIL bp_resume: got %0h/%0h expected ab/1", tx_data, tx_valid); end
    tick(0, 16'h0000, 1);
    checks++;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL bp_end: got %0h expected 0", tx_valid); end
  endtask

  task automatic test_burst();
    int first_idle;
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 16'($urandom), 0);
    checks += 2;
    if (fifo_level !== 4'd8) begin failures++; $display("FAIL burst_level: got %0d expected 8", fifo_level); end
    if (overflow !== 1'b1) begin failures++; $display("FAIL burst_overflow: got %0h expected 1", overflow); end
    first_idle = -1;
    for (int i = 1; i <= 32; i++) begin
      tick(0, 16'h0000, 1);
      if (tx_valid === 1'b1) begin
        checks++;
        if (tx_data !== exp_byte()) begin failures++; $display("FAIL burst_byte[%0d]: got %0h expected %0h", i, tx_data, exp_byte()); end
      end else if (first_idle < 0) begin
        first_idle = i;
      end
    end
    checks += 2;
    if (first_idle != 27) begin failures++; $display("FAIL burst_gapless: got %0d expected 27", first_idle); end
    if (hdr_q.size() != 9) begin failures++; $display("FAIL burst_frames: got %0d expected 9", hdr_q.size()); end
    for (int i = 0; i < 9 && i < hdr_q.size(); i++) begin
      checks++;
      if (hdr_q[i] !== 8'(i)) begin failures++; $display("FAIL burst_hdr[%0d]: got %0h expected %0h", i, hdr_q[i], i); end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int b = 0; b < 257; b++) begin
      tick(1, 16'($urandom), 1);
      for (int k = 0; k < 3; k++) begin
        tick(0, 16'h0000, 1);
        checks++;
        if (tx_valid !== 1'(bleft > 0) || (tx_valid === 1'b1 && tx_data !== exp_byte())) begin
          failures++; $display("FAIL wrap_stream[%0d]: got %0h/%0h expected %0h/%0h", b, tx_valid, tx_data, bleft > 0, exp_byte());
        end
      end
    end
    for (int k = 0; k < 8; k++) tick(0, 16'h0000, 1);
    checks += 4;
    if (hdr_q.size() != 257) begin failures++; $display("FAIL wrap_frames: got %0d expected 257", hdr_q.size()); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_overflow: got %0h expected 0", overflow); end
    if (hdr_q.size() >= 257) begin
      if (hdr_q[255] !== 8'hFF) begin failures++; $display("FAIL wrap_hdr_ff: got %0h expected ff", hdr_q[255]); end
      if (hdr_q[256] !== 8'h00) begin failures++; $display("FAIL wrap_hdr_00: got %0h expected 00", hdr_q[256]); end
    end else begin
      failures += 2; $display("FAIL wrap_hdr_tail: got %0d headers expected 257", hdr_q.size());
    end
  endtask

  task automatic test_full_pop();
    do_reset();
    tick(1, 16'h5555, 0);
    tick(0, 16'h0000, 0);
    tick(0, 16'h0000, 0);
    for (int i = 0; i < 8; i++) tick(1, 16'($urandom), 0);
    checks++;
    if (fifo_level !== 4'd8) begin failures++; $display("FAIL fp_prefill: got %0d expected 8", fifo_level); end
    tick(0, 16'h0000, 1);
    tick(0, 16'h0000, 1);
    tick(1, 16'hBEEF, 1);
    checks += 4;
    if (fifo_level !== 4'd8) begin failures++; $display("FAIL fp_level: got %0d expected 8", fifo_level); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL fp_overflow: got %0h expected 0", overflow); end
    if (tx_valid !== 1'b1) begin failures++; $display("FAIL fp_chain_valid: got %0h expected 1", tx_valid); end
    if (tx_data !== 8'h01) begin failures++; $display("FAIL fp_chain_hdr: got %0h expected 01", tx_data); end
    for (int i = 0; i < 40; i++) tick(0, 16'h0000, 1);
    checks++;
    if (hdr_q.size() != 10) begin failures++; $display("FAIL fp_frames: got %0d expected 10", hdr_q.size()); end
    for (int i = 0; i < 10 && i < hdr_q.size(); i++) begin
      checks++;
      if (hdr_q[i] !== 8'(i)) begin failures++; $display("FAIL fp_hdr[%0d]: got %0h expected %0h", i, hdr_q[i], i); end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int i = 0; i < 10; i++) tick(1, 16'($urandom), 0);
    tick(0, 16'h0000, 1);
    checks += 2;
    if (overflow !== 1'b1) begin failures++; $display("FAIL rm_pre_overflow: got %0h expected 1", overflow); end
    if (tx_data !== exp_byte() || bleft != 2) begin failures++; $display("FAIL rm_pre_msb: got %0h expected %0h", tx_data, exp_byte()); end
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (tx_valid !== 1'b0) begin failures++; $display("FAIL rm_valid: got %0h expected 0", tx_valid); end
    if (overflow !== 1'b0) begin failures++; $display("FAIL rm_overflow: got %0h expected 0", overflow); end
    if (fifo_level !== 4'd0) begin failures++; $display("FAIL rm_level: got %0d expected 0", fifo_level); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy: got %0h expected 0", busy); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    hdr_q.delete();
    tick(1, 16'h0F0F, 1);
    tick(0, 16'h0000, 1);
    tick(0, 16'h0000, 1);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin failures++; $display("FAIL rm_after_hdr: got %0h/%0h expected 1/00", tx_valid, tx_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 2) == 0, 16'($urandom), (i % 200) < 150 ? ($urandom_range(0, 3) != 0) : 1'b0);
      checks += 4;
      if (tx_valid !== 1'(bleft > 0)) begin failures++; $display("FAIL rnd_valid[%0d]: got %0h expected %0h", i, tx_valid, bleft > 0); end
      else if (tx_valid === 1'b1 && tx_data !== exp_byte()) begin failures++; $display("FAIL rnd_data[%0d]: got %0h expected %0h", i, tx_data, exp_byte()); end
      if (fifo_level !== 4'(mq.size())) begin failures++; $display("FAIL rnd_level[%0d]: got %0d expected %0d", i, fifo_level, mq.size()); end
      if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_overflow[%0d]: got %0h expected %0h", i, overflow, m_ovf); end
      if (busy !== 1'(bleft > 0)) begin failures++; $display("FAIL rnd_busy[%0d]: got %0h expected %0h", i, busy, bleft > 0); end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_burst();
    test_wrap();
    test_full_pop();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
